load_store_unit: RTL and testbench

Sits between the core execute stage and the byte-addressable data memory. Accepts one load or store request at a time and computes the effective address. Checks alignment and funct3 legality before any memory access. Drives the memory read/write ports, waits the fixed read latency, and sign- or zero-extends load data. Returns a single-cycle response carrying writeback data or an exception record.

---
 rtl/load_store_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: effective address, alignment and funct3 pre-check, memory issue,
// fixed-latency read wait and load extension, returning a one-cycle response.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_exc,
  output logic [3:0]  resp_cause,
  output logic [31:0] resp_tval,
  output logic        mem_r_en,
  output logic [31:0] mem_r_addr,
  output logic [1:0]  mem_r_mode,
  input  logic [31:0] mem_r_data,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [1:0]  mem_w_mode,
  input  logic [1:0]  mem_state
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;
  localparam logic [1:0] MEM_OK            = 2'b00;

  logic [1:0]      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            store_q, store_n;
  logic [2:0]      funct3_q, funct3_n;
  logic [XLEN-1:0] ea_q, ea_n;
  logic [4:0]      rd_q, rd_n;

  logic            req_ready_n, resp_valid_n, resp_exc_n, mem_r_en_n, mem_w_en_n;
  logic [4:0]      resp_rd_n;
  logic [3:0]      resp_cause_n;
  logic [XLEN-1:0] resp_data_n, resp_tval_n, mem_r_addr_n, mem_w_addr_n, mem_w_data_n;
  logic [1:0]      mem_r_mode_n, mem_w_mode_n;

  logic [XLEN-1:0] ea_c;
  logic [XLEN-1:0] ext_c;
  logic            legal_c, misalign_c, fault_c;

  assign ea_c    = req_base + req_offset;
  assign fault_c = (mem_state != MEM_OK);

  // Request legality: loads reject 011/110/111, stores accept only 000/001/010
  always_comb begin
    if (req_store) legal_c = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    else           legal_c = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
    misalign_c = ((req_funct3[1:0] == 2'b01) && ea_c[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
  end

  // Load extension; funct3[2] marks the unsigned variants
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ext_c = {{24{~funct3_q[2] & mem_r_data[7]}}, mem_r_data[7:0]};
      2'b01:   ext_c = {{16{~funct3_q[2] & mem_r_data[15]}}, mem_r_data[15:0]};
      default: ext_c = mem_r_data;
    endcase
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    store_n      = store_q;
    funct3_n     = funct3_q;
    ea_n         = ea_q;
    rd_n         = rd_q;
    req_ready_n  = req_ready;
    resp_valid_n = 1'b0;
    resp_rd_n    = resp_rd;
    resp_data_n  = resp_data;
    resp_exc_n   = resp_exc;
    resp_cause_n = resp_cause;
    resp_tval_n  = resp_tval;
    mem_r_en_n   = 1'b0;
    mem_r_addr_n = mem_r_addr;
    mem_r_mode_n = mem_r_mode;
    mem_w_en_n   = 1'b0;
    mem_w_addr_n = mem_w_addr;
    mem_w_data_n = mem_w_data;
    mem_w_mode_n = mem_w_mode;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          store_n     = req_store;
          funct3_n    = req_funct3;
          ea_n        = ea_c;
          rd_n        = req_rd;
          req_ready_n = 1'b0;
          if (!legal_c || misalign_c) begin
            state_n      = S_RESP;
            resp_valid_n = 1'b1;
            resp_rd_n    = req_store ? 5'd0 : req_rd;
            resp_data_n  = '0;
            resp_exc_n   = 1'b1;
            resp_cause_n = !legal_c ? CAUSE_ILLEGAL :
                           (req_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN);
            resp_tval_n  = ea_c;
          end else if (req_store) begin
            state_n      = S_ISSUE;
            mem_w_en_n   = 1'b1;
            mem_w_addr_n = ea_c;
            mem_w_data_n = req_wdata;
            mem_w_mode_n = req_funct3[1:0];
          end else begin
            state_n      = S_ISSUE;
            mem_r_en_n   = 1'b1;
            mem_r_addr_n = ea_c;
            mem_r_mode_n = req_funct3[1:0];
          end
        end
      end
      S_ISSUE: begin
        if (store_q) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_rd_n    = 5'd0;
          resp_data_n  = '0;
          resp_exc_n   = fault_c;
          resp_cause_n = fault_c ? CAUSE_ST_FAULT : CAUSE_NONE;
          resp_tval_n  = fault_c ? ea_q : '0;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(READ_LATENCY);
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_rd_n    = rd_q;
          resp_data_n  = fault_c ? '0 : ext_c;
          resp_exc_n   = fault_c;
          resp_cause_n = fault_c ? CAUSE_LD_FAULT : CAUSE_NONE;
          resp_tval_n  = fault_c ? ea_q : '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n     = S_IDLE;
        req_ready_n = 1'b1;
      end
    endcase
  end

  // Single register bank; clk_enable low holds every bit including pending pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      ea_q       <= '0;
      rd_q       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rd    <= '0;
      resp_data  <= '0;
      resp_exc   <= 1'b0;
      resp_cause <= '0;
      resp_tval  <= '0;
      mem_r_en   <= 1'b0;
      mem_r_addr <= '0;
      mem_r_mode <= '0;
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      mem_w_mode <= '0;
    end else if (clk_enable) begin
      state      <= state_n;
      cnt        <= cnt_n;
      store_q    <= store_n;
      funct3_q   <= funct3_n;
      ea_q       <= ea_n;
      rd_q       <= rd_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rd    <= resp_rd_n;
      resp_data  <= resp_data_n;
      resp_exc   <= resp_exc_n;
      resp_cause <= resp_cause_n;
      resp_tval  <= resp_tval_n;
      mem_r_en   <= mem_r_en_n;
      mem_r_addr <= mem_r_addr_n;
      mem_r_mode <= mem_r_mode_n;
      mem_w_en   <= mem_w_en_n;
      mem_w_addr <= mem_w_addr_n;
      mem_w_data <= mem_w_data_n;
      mem_w_mode <= mem_w_mode_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with READ_LATENCY=1 and one with 3.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, clk_enable, req_valid1, req_valid3, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata, mem_r_data;
  logic [4:0]  req_rd;
  logic [1:0]  mem_state;

  logic        req_ready1, resp_valid1, resp_exc1, mem_r_en1, mem_w_en1;
  logic [4:0]  resp_rd1;
  logic [3:0]  resp_cause1;
  logic [31:0] resp_data1, resp_tval1, mem_r_addr1, mem_w_addr1, mem_w_data1;
  logic [1:0]  mem_r_mode1, mem_w_mode1;

  logic        req_ready3, resp_valid3, resp_exc3, mem_r_en3, mem_w_en3;
  logic [4:0]  resp_rd3;
  logic [3:0]  resp_cause3;
  logic [31:0] resp_data3, resp_tval3, mem_r_addr3, mem_w_addr3, mem_w_data3;
  logic [1:0]  mem_r_mode3, mem_w_mode3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid1), .resp_rd(resp_rd1), .resp_data(resp_data1),
    .resp_exc(resp_exc1), .resp_cause(resp_cause1), .resp_tval(resp_tval1),
    .mem_r_en(mem_r_en1), .mem_r_addr(mem_r_addr1), .mem_r_mode(mem_r_mode1),
    .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en1), .mem_w_addr(mem_w_addr1), .mem_w_data(mem_w_data1),
    .mem_w_mode(mem_w_mode1), .mem_state(mem_state)
  );

  load_store_unit #(.READ_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid3), .resp_rd(resp_rd3), .resp_data(resp_data3),
    .resp_exc(resp_exc3), .resp_cause(resp_cause3), .resp_tval(resp_tval3),
    .mem_r_en(mem_r_en3), .mem_r_addr(mem_r_addr3), .mem_r_mode(mem_r_mode3),
    .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en3), .mem_w_addr(mem_w_addr3), .mem_w_data(mem_w_data3),
    .mem_w_mode(mem_w_mode3), .mem_state(mem_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd);
    req_store  = st;
    req_funct3 = f3;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  // Load on the latency-1 unit: mem_r_en in cycle 1, response in cycle 3
  task automatic load1(input string tag, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [1:0] exp_mode,
                       input logic [31:0] exp_data);
    set_req(1'b0, f3, base, off, 32'h0, 5'd3);
    mem_r_data = rdata;
    mem_state  = 2'b00;
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    chk({tag, "_ren"},   32'(mem_r_en1), 32'd1);
    chk({tag, "_raddr"}, mem_r_addr1, exp_addr);
    chk({tag, "_rmode"}, 32'(mem_r_mode1), 32'(exp_mode));
    chk({tag, "_ready"}, 32'(req_ready1), 32'd0);
    tick();
    chk({tag, "_ren_off"}, 32'(mem_r_en1), 32'd0);
    chk({tag, "_early"},   32'(resp_valid1), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(resp_valid1), 32'd1);
    chk({tag, "_data"},  resp_data1, exp_data);
    chk({tag, "_exc"},   32'(resp_exc1), 32'd0);
    chk({tag, "_rd"},    32'(resp_rd1), 32'd3);
    tick();
    chk({tag, "_done"},  32'(resp_valid1), 32'd0);
    chk({tag, "_idle"},  32'(req_ready1), 32'd1);
  endtask

  // Pre-check exception on the latency-1 unit: response in cycle 1, no memory access
  task automatic exc1(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] base, input logic [31:0] off,
                      input logic [3:0] exp_cause, input logic [31:0] exp_tval);
    set_req(st, f3, base, off, 32'hCAFEF00D, 5'd9);
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    chk({tag, "_valid"}, 32'(resp_valid1), 32'd1);
    chk({tag, "_exc"},   32'(resp_exc1), 32'd1);
    chk({tag, "_cause"}, 32'(resp_cause1), 32'(exp_cause));
    chk({tag, "_tval"},  resp_tval1, exp_tval);
    chk({tag, "_data"},  resp_data1, 32'h0);
    chk({tag, "_ren"},   32'(mem_r_en1), 32'd0);
    chk({tag, "_wen"},   32'(mem_w_en1), 32'd0);
    tick();
    chk({tag, "_ren2"},  32'(mem_r_en1), 32'd0);
    chk({tag, "_wen2"},  32'(mem_w_en1), 32'd0);
    chk({tag, "_done"},  32'(resp_valid1), 32'd0);
    chk({tag, "_idle"},  32'(req_ready1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw;
    rst        = 1'b1;
    clk_enable = 1'b1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    set_req(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    mem_r_data = 32'h0;
    mem_state  = 2'b00;
    tick();
    tick();
    chk("rst_ready1", 32'(req_ready1), 32'd1);
    chk("rst_ready3", 32'(req_ready3), 32'd1);
    chk("rst_resp",   32'(resp_valid1), 32'd0);
    chk("rst_ren",    32'(mem_r_en1), 32'd0);
    chk("rst_wen",    32'(mem_w_en1), 32'd0);
    chk("rst_waddr",  mem_w_addr1, 32'h0);
    chk("rst_data",   resp_data1, 32'h0);
    rst = 1'b0;
    tick();

    // SW 0xDEADBEEF to 0x100+4
    set_req(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd7);
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    chk("sw_wen",   32'(mem_w_en1), 32'd1);
    chk("sw_waddr", mem_w_addr1, 32'h104);
    chk("sw_wmode", 32'(mem_w_mode1), 32'd2);
    chk("sw_wdata", mem_w_data1, 32'hDEADBEEF);
    chk("sw_ren",   32'(mem_r_en1), 32'd0);
    chk("sw_early", 32'(resp_valid1), 32'd0);
    tick();
    chk("sw_valid", 32'(resp_valid1), 32'd1);
    chk("sw_exc",   32'(resp_exc1), 32'd0);
    chk("sw_rd",    32'(resp_rd1), 32'd0);
    chk("sw_wen2",  32'(mem_w_en1), 32'd0);
    chk("sw_hold",  mem_w_addr1, 32'h104);
    tick();
    chk("sw_done",  32'(resp_valid1), 32'd0);
    chk("sw_idle",  32'(req_ready1), 32'd1);

    load1("lw",    3'b010, 32'h100,      32'h4,        32'hDEADBEEF, 32'h104, 2'b10, 32'hDEADBEEF);
    load1("lb",    3'b000, 32'h200,      32'h1,        32'h000000F0, 32'h201, 2'b00, 32'hFFFFFFF0);
    load1("lbu",   3'b100, 32'h200,      32'h1,        32'h000000F0, 32'h201, 2'b00, 32'h000000F0);
    load1("lh",    3'b001, 32'h200,      32'h2,        32'h00008001, 32'h202, 2'b01, 32'hFFFF8001);
    load1("lhu",   3'b101, 32'h200,      32'h2,        32'h00008001, 32'h202, 2'b01, 32'h00008001);
    load1("lbpos", 3'b000, 32'h300,      32'h7,        32'h0000007F, 32'h307, 2'b00, 32'h0000007F);
    load1("lhneg", 3'b001, 32'h108,      32'hFFFFFFFA, 32'h00007FFF, 32'h102, 2'b01, 32'h00007FFF);
    load1("wrap",  3'b010, 32'hFFFFFFFC, 32'h8,        32'h12345678, 32'h4,   2'b10, 32'h12345678);

    exc1("lw_mis",  1'b0, 3'b010, 32'h100, 32'h2, 4'd4, 32'h102);
    exc1("lh_mis",  1'b0, 3'b001, 32'h100, 32'h1, 4'd4, 32'h101);
    exc1("sh_mis",  1'b1, 3'b001, 32'h200, 32'h3, 4'd6, 32'h203);
    exc1("sw_mis",  1'b1, 3'b010, 32'h100, 32'h2, 4'd6, 32'h102);
    exc1("ld_ill",  1'b0, 3'b011, 32'h100, 32'h0, 4'd2, 32'h100);
    exc1("st_ill",  1'b1, 3'b100, 32'h100, 32'h0, 4'd2, 32'h100);
    exc1("ill_mis", 1'b0, 3'b111, 32'h100, 32'h3, 4'd2, 32'h103);

    // SB with memory fault held across the write and response cycles
    set_req(1'b1, 3'b000, 32'h500, 32'h1, 32'h000000AA, 5'd2);
    mem_state  = 2'b01;
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    chk("sbf_wen",   32'(mem_w_en1), 32'd1);
    chk("sbf_waddr", mem_w_addr1, 32'h501);
    chk("sbf_wmode", 32'(mem_w_mode1), 32'd0);
    tick();
    chk("sbf_valid", 32'(resp_valid1), 32'd1);
    chk("sbf_exc",   32'(resp_exc1), 32'd1);
    chk("sbf_cause", 32'(resp_cause1), 32'd7);
    chk("sbf_tval",  resp_tval1, 32'h501);
    mem_state = 2'b00;
    tick();
    chk("sbf_idle",  32'(req_ready1), 32'd1);

    // Freeze while mem_r_en and resp_valid are pending on the latency-1 unit
    set_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 5'd4);
    mem_r_data = 32'h0BADF00D;
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    clk_enable = 1'b0;
    tick();
    chk("frz_ren_hold", 32'(mem_r_en1), 32'd1);
    clk_enable = 1'b1;
    tick();
    chk("frz_ren_off",  32'(mem_r_en1), 32'd0);
    chk("frz_early",    32'(resp_valid1), 32'd0);
    tick();
    chk("frz_valid",    32'(resp_valid1), 32'd1);
    clk_enable = 1'b0;
    tick();
    chk("frz_vhold",    32'(resp_valid1), 32'd1);
    chk("frz_data",     resp_data1, 32'h0BADF00D);
    clk_enable = 1'b1;
    tick();
    chk("frz_done",     32'(resp_valid1), 32'd0);
    chk("frz_idle",     32'(req_ready1), 32'd1);

    // Latency-3 load with memory fault: response in cycle 5
    set_req(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd9);
    mem_r_data = 32'h00000055;
    mem_state  = 2'b01;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    chk("l3f_ren", 32'(mem_r_en3), 32'd1);
    tick();
    tick();
    tick();
    chk("l3f_c4",    32'(resp_valid3), 32'd0);
    tick();
    chk("l3f_valid", 32'(resp_valid3), 32'd1);
    chk("l3f_exc",   32'(resp_exc3), 32'd1);
    chk("l3f_cause", 32'(resp_cause3), 32'd5);
    chk("l3f_data",  resp_data3, 32'h0);
    chk("l3f_tval",  resp_tval3, 32'h300);
    mem_state = 2'b00;
    tick();
    chk("l3f_done",  32'(resp_valid3), 32'd0);
    chk("l3f_idle",  32'(req_ready3), 32'd1);

    // Latency-3 load with two frozen cycles in WAIT: response moves from cycle 5 to 7
    set_req(1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 5'd6);
    mem_r_data = 32'hA5A5A5A5;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    tick();
    clk_enable = 1'b0;
    tick();
    tick();
    clk_enable = 1'b1;
    tick();
    chk("l3z_c5", 32'(resp_valid3), 32'd0);
    tick();
    chk("l3z_c6", 32'(resp_valid3), 32'd0);
    tick();
    chk("l3z_c7",   32'(resp_valid3), 32'd1);
    chk("l3z_data", resp_data3, 32'hA5A5A5A5);
    chk("l3z_rd",   32'(resp_rd3), 32'd6);
    tick();
    chk("l3z_idle", 32'(req_ready3), 32'd1);

    // Reset during WAIT drops the load without a response
    set_req(1'b0, 3'b010, 32'h700, 32'h0, 32'h0, 5'd1);
    mem_r_data = 32'h11111111;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_ready", 32'(req_ready3), 32'd1);
    chk("rstw_resp",  32'(resp_valid3), 32'd0);
    chk("rstw_ren",   32'(mem_r_en3), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid3) saw = 1'b1;
    end
    chk("rstw_noresp", 32'(saw), 32'd0);

    set_req(1'b0, 3'b100, 32'h710, 32'h0, 32'h0, 5'd8);
    mem_r_data = 32'h00000080;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    tick();
    tick();
    tick();
    chk("post_c4",    32'(resp_valid3), 32'd0);
    tick();
    chk("post_valid", 32'(resp_valid3), 32'd1);
    chk("post_data",  resp_data3, 32'h00000080);
    chk("post_exc",   32'(resp_exc3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
